vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Read side of the 640x480 frame buffer: generates 640x480@60 Hz VGA timing on the 25 MHz pixel clock.
- Drives read-enable and read-address into the BRAM read port, and takes the 12-bit pixel back.
- Outputs 4:4:4 RGB with hsync, vsync and data-enable, all aligned to the 1-cycle BRAM read latency.
- Sits between the mem_bram read port and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- WIDTH, 12, BRAM pixel width ({R[11:8],G[7:4],B[3:0]})
- DEPTH, H_ACTIVE*V_ACTIVE, BRAM depth in pixels

Ports:
- i_clk  in  1  pixel clock, 25 MHz; same clock as the BRAM read clock
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  display enable; when low, reads are suppressed and RGB is blanked
- o_rd  out  1  BRAM read enable
- o_rd_addr  out  $clog2(DEPTH)  BRAM read address
- i_bram_data  in  WIDTH  BRAM read data, valid 1 clock after the o_rd/o_rd_addr edge
- o_vga_r  out  4  red
- o_vga_g  out  4  green
- o_vga_b  out  4  blue
- o_hsync  out  1  horizontal sync, active low
- o_vsync  out  1  vertical sync, active low
- o_de  out  1  active-video flag, aligned with RGB
- o_frame_start  out  1  1-clock pulse with the first pixel of each frame, aligned with RGB

Behaviour:
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0, o_rd = 0, o_rd_addr = 0
  - RGB = 0, o_de = 0, o_frame_start = 0
  - o_hsync = o_vsync = 1
- Counters:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL = 800), then wraps to 0.
  - v_cnt increments on the h_cnt wrap and counts 0..V_TOTAL-1 (V_TOTAL = 525), then wraps to 0.
- Regions:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync asserted (low) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656, 752)
  - vsync asserted (low) for v_cnt in [490, 492)
- Stage 1 (registered from counters):
  - o_rd = active && i_en
  - o_rd_addr = pixel index of (h_cnt, v_cnt)
- Address generation:
  - Maintained incrementally with no multiplier.
  - Increments by 1 after every active pixel, whether or not i_en is set.
  - Holds during blanking.
  - Returns to 0 when v_cnt wraps to 0.
  - Last address of a frame is DEPTH-1 (307199); never exceeds it.
- Stage 2 (BRAM): i_bram_data is valid the clock after stage 1.
- Stage 3 (registered outputs):
  - RGB = i_bram_data split 4/4/4 when the delayed (active && i_en) is 1; otherwise 0.
  - o_de = delayed active.
  - o_hsync, o_vsync and o_frame_start are delayed through the same number of registers, so all of them are mutually aligned.
- Latency:
  - Pixel at address A appears on RGB exactly 2 clocks after the clock edge where o_rd = 1 and o_rd_addr = A.
  - Total latency from counter to pins is 3 clocks.
- i_en:
  - Sampled every clock and affects only o_rd and RGB blanking.
  - Sync timing, o_de and address advance are unaffected.
  - Toggling mid-frame therefore keeps addresses and screen position aligned.
- o_frame_start: high for exactly 1 clock when the (0,0) pixel reaches the outputs, once per 420000 clocks.
- Reset mid-frame: all state returns to reset values immediately; the next frame starts at (0,0), address 0.

Test Plan:
- Reset, release, en=1:
  - First 640 o_rd=1 clocks carry addresses 0..639 consecutively.
  - o_rd=0 for the next 160 clocks.
  - Line 1 starts at 640.
- Hsync/vsync timing:
  - o_hsync low for exactly 96 clocks, starting 656 clocks after o_de rises on a line (measured at the outputs).
  - Line period is 800 clocks.
  - o_vsync low for exactly 2 lines (1600 clocks).
  - Frame period is 420000 clocks.
- BRAM model returning data = addr[11:0]:
  - Every clock with o_de=1 shows RGB == {r,g,b} of the pixel index.
  - Confirms the 2-clock alignment.
- Frame wrap:
  - Last read of a frame has address 307199.
  - Next read has address 0, coinciding with o_frame_start one clock-aligned with first RGB pixel 0x000.
- Blanking with i_en:
  - i_en=0 for lines 10..19 → o_rd=0 and RGB=0 there.
  - o_de and syncs are unchanged.
  - Line 20 first address is 12800.
- i_rst pulse at h=300, v=200:
  - Outputs are at reset values asynchronously.
  - After release, the first read address is 0 and o_frame_start fires 3 clocks later.

Source files
------------

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_reader
// Description : 640x480@60 VGA timing generator that reads pixels from a
//               1-cycle-latency BRAM and drives aligned RGB/sync/DE pins.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WIDTH    = 12,
  parameter int DEPTH    = H_ACTIVE * V_ACTIVE
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  output logic                     o_rd,
  output logic [$clog2(DEPTH)-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]         i_bram_data,
  output logic [3:0]               o_vga_r,
  output logic [3:0]               o_vga_g,
  output logic [3:0]               o_vga_b,
  output logic                     o_hsync,
  output logic                     o_vsync,
  output logic                     o_de,
  output logic                     o_frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int AW       = $clog2(DEPTH);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [AW-1:0] r_pix;

  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_on;
  logic w_vs_on;
  logic w_first;

  // stage 1
  logic          r_rd;
  logic [AW-1:0] r_rd_addr;
  logic          r_de1;
  logic          r_hs1;
  logic          r_vs1;
  logic          r_fs1;
  // stage 2
  logic          r_rgb_en2;
  logic          r_de2;
  logic          r_hs2;
  logic          r_vs2;
  logic          r_fs2;
  // stage 3
  logic [3:0]    r_vga_r;
  logic [3:0]    r_vga_g;
  logic [3:0]    r_vga_b;
  logic          r_de3;
  logic          r_hs3;
  logic          r_vs3;
  logic          r_fs3;

  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_on  = (r_h_cnt >= HW'(HS_START)) && (r_h_cnt < HW'(HS_END));
  assign w_vs_on  = (r_v_cnt >= VW'(VS_START)) && (r_v_cnt < VW'(VS_END));
  assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // Running pixel index: advances on every active pixel regardless of i_en,
  // so screen position and address never drift apart.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix <= '0;
    end else if (w_h_last && w_v_last) begin
      r_pix <= '0;
    end else if (w_active) begin
      r_pix <= (r_pix == AW'(DEPTH - 1)) ? '0 : r_pix + AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd      <= 1'b0;
      r_rd_addr <= '0;
      r_de1     <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_fs1     <= 1'b0;
    end else begin
      r_rd  <= w_active && i_en;
      r_de1 <= w_active;
      r_hs1 <= ~w_hs_on;
      r_vs1 <= ~w_vs_on;
      r_fs1 <= w_first;
      if (w_active) begin
        r_rd_addr <= r_pix;
      end
    end
  end

  // Stage 2 matches the BRAM read latency for the side-band signals.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rgb_en2 <= 1'b0;
      r_de2     <= 1'b0;
      r_hs2     <= 1'b1;
      r_vs2     <= 1'b1;
      r_fs2     <= 1'b0;
    end else begin
      r_rgb_en2 <= r_rd;
      r_de2     <= r_de1;
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_fs2     <= r_fs1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
      r_de3   <= 1'b0;
      r_hs3   <= 1'b1;
      r_vs3   <= 1'b1;
      r_fs3   <= 1'b0;
    end else begin
      r_vga_r <= r_rgb_en2 ? i_bram_data[11:8] : 4'd0;
      r_vga_g <= r_rgb_en2 ? i_bram_data[7:4]  : 4'd0;
      r_vga_b <= r_rgb_en2 ? i_bram_data[3:0]  : 4'd0;
      r_de3   <= r_de2;
      r_hs3   <= r_hs2;
      r_vs3   <= r_vs2;
      r_fs3   <= r_fs2;
    end
  end

  assign o_rd          = r_rd;
  assign o_rd_addr     = r_rd_addr;
  assign o_vga_r       = r_vga_r;
  assign o_vga_g       = r_vga_g;
  assign o_vga_b       = r_vga_b;
  assign o_hsync       = r_hs3;
  assign o_vsync       = r_vs3;
  assign o_de          = r_de3;
  assign o_frame_start = r_fs3;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_reader
// Description : Directed bench; full-size instance for line/address timing,
//               shrunk-timing instance for frame wrap, vsync and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic        a_rst, a_en, a_rd, a_hs, a_vs, a_de, a_fs;
  logic [18:0] a_addr;
  logic [11:0] a_bram = '0;
  logic [3:0]  a_r, a_g, a_b;
  // shrunk instance: 8x6 active, 15x10 total
  logic        b_rst, b_en, b_rd, b_hs, b_vs, b_de, b_fs;
  logic [5:0]  b_addr;
  logic [11:0] b_bram = '0;
  logic [3:0]  b_r, b_g, b_b;

  vga_frame_reader u_a (
    .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .o_rd(a_rd), .o_rd_addr(a_addr),
    .i_bram_data(a_bram), .o_vga_r(a_r), .o_vga_g(a_g), .o_vga_b(a_b),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_frame_start(a_fs)
  );

  vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .o_rd(b_rd), .o_rd_addr(b_addr),
    .i_bram_data(b_bram), .o_vga_r(b_r), .o_vga_g(b_g), .o_vga_b(b_b),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_frame_start(b_fs)
  );

  // BRAM models: data = address, one clock of read latency
  always @(posedge clk) if (a_rd) a_bram <= a_addr[11:0];
  always @(posedge clk) if (b_rd) b_bram <= {6'd0, b_addr};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic en_line(input int v);
    return !(v >= 10 && v <= 19);
  endfunction

  typedef struct {
    int          k;
    logic        rd;
    logic [18:0] addr;
    logic        de;
    logic        hs;
    logic        fs;
    logic [11:0] rgb;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  initial begin
    int ti, bad_rd, bad_addr, bad_out, n_hs_low, n_de, n_rd;
    int fs1, fs2, vs_start, n_vs_low, n_hs_b, max_addr, prev_addr, wrap_k, wrap_addr;
    int bad_fs, bad_pix, e_pix;
    logic prev_valid;

    // k = clock edges since reset release; o_rd shows position k-1, pins show k-3
    tbl[0]  = '{0,     1'b0, 19'd0,     1'b0, 1'b1, 1'b0, 12'h000};
    tbl[1]  = '{1,     1'b1, 19'd0,     1'b0, 1'b1, 1'b0, 12'h000};
    tbl[2]  = '{2,     1'b1, 19'd1,     1'b0, 1'b1, 1'b0, 12'h000};
    tbl[3]  = '{3,     1'b1, 19'd2,     1'b1, 1'b1, 1'b1, 12'h000};
    tbl[4]  = '{4,     1'b1, 19'd3,     1'b1, 1'b1, 1'b0, 12'h001};
    tbl[5]  = '{640,   1'b1, 19'd639,   1'b1, 1'b1, 1'b0, 12'h27D};
    tbl[6]  = '{641,   1'b0, 19'd639,   1'b1, 1'b1, 1'b0, 12'h27E};
    tbl[7]  = '{643,   1'b0, 19'd639,   1'b0, 1'b1, 1'b0, 12'h000};
    tbl[8]  = '{659,   1'b0, 19'd639,   1'b0, 1'b0, 1'b0, 12'h000};
    tbl[9]  = '{754,   1'b0, 19'd639,   1'b0, 1'b0, 1'b0, 12'h000};
    tbl[10] = '{755,   1'b0, 19'd639,   1'b0, 1'b1, 1'b0, 12'h000};
    tbl[11] = '{801,   1'b1, 19'd640,   1'b0, 1'b1, 1'b0, 12'h000};
    tbl[12] = '{803,   1'b1, 19'd642,   1'b1, 1'b1, 1'b0, 12'h280};
    tbl[13] = '{8001,  1'b0, 19'd6400,  1'b0, 1'b1, 1'b0, 12'h000};
    tbl[14] = '{8003,  1'b0, 19'd6402,  1'b1, 1'b1, 1'b0, 12'h000};
    tbl[15] = '{16001, 1'b1, 19'd12800, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[16] = '{16003, 1'b1, 19'd12802, 1'b1, 1'b1, 1'b0, 12'h200};

    a_rst = 1'b1; a_en = 1'b1;
    b_rst = 1'b1; b_en = 1'b1;
    repeat (3) tick();
    a_rst = 1'b0;

    // ---------------- full-size sweep: lines 0..20, i_en low on lines 10..19
    ti = 0; bad_rd = 0; bad_addr = 0; bad_out = 0; n_hs_low = 0; n_de = 0; n_rd = 0;
    for (int k = 0; k <= 16010; k++) begin
      if (k > 0) tick();
      if (ti < NV && tbl[ti].k == k) begin
        chk($sformatf("a rd k=%0d", k),   a_rd,            tbl[ti].rd);
        chk($sformatf("a addr k=%0d", k), a_addr,          tbl[ti].addr);
        chk($sformatf("a de k=%0d", k),   a_de,            tbl[ti].de);
        chk($sformatf("a hs k=%0d", k),   a_hs,            tbl[ti].hs);
        chk($sformatf("a fs k=%0d", k),   a_fs,            tbl[ti].fs);
        chk($sformatf("a rgb k=%0d", k),  {a_r, a_g, a_b}, tbl[ti].rgb);
        ti++;
      end
      if (k >= 1) begin
        int p, h, v;
        logic e_rd;
        p = k - 1; h = p % 800; v = (p / 800) % 525;
        e_rd = (h < 640) && (v < 480) && en_line(v);
        if (a_rd !== e_rd) bad_rd++;
        if (e_rd && a_addr !== 19'(v * 640 + h)) bad_addr++;
        if (a_rd) n_rd++;
      end
      begin
        int q, h, v;
        logic e_act, e_hs, e_vs, e_fs;
        logic [11:0] e_rgb;
        q = k - 3;
        if (q < 0) begin
          e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = '0;
        end else begin
          h = q % 800; v = (q / 800) % 525;
          e_act = (h < 640) && (v < 480);
          e_hs  = !(h >= 656 && h < 752);
          e_vs  = !(v >= 490 && v < 492);
          e_fs  = (h == 0) && (v == 0);
          e_rgb = (e_act && en_line(v)) ? 12'(v * 640 + h) : 12'h000;
        end
        if ({a_de, a_hs, a_vs, a_fs, a_r, a_g, a_b} !== {e_act, e_hs, e_vs, e_fs, e_rgb}) bad_out++;
        if (!a_hs) n_hs_low++;
        if (a_de) n_de++;
      end
      a_en = en_line((k / 800) % 525);
    end
    chk("a rd sweep errors",      bad_rd,   0);
    chk("a addr sweep errors",    bad_addr, 0);
    chk("a pins sweep errors",    bad_out,  0);
    chk("a hsync low clocks",     n_hs_low, 1920);
    chk("a de clocks",            n_de,     12808);
    chk("a rd clocks",            n_rd,     6410);

    // ---------------- shrunk instance: two frames
    b_rst = 1'b0;
    chk("b reset state", {b_rd, b_addr, b_de, b_hs, b_vs, b_fs, b_r, b_g, b_b},
        {1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    fs1 = -1; fs2 = -1; vs_start = -1; n_vs_low = 0; n_hs_b = 0; max_addr = 0;
    prev_addr = 0; prev_valid = 1'b0; wrap_k = -1; wrap_addr = -1;
    bad_fs = 0; bad_pix = 0; e_pix = 0;
    for (int k = 1; k <= 320; k++) begin
      tick();
      if (b_fs) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
        if (!b_de || {b_r, b_g, b_b} !== 12'h000) bad_fs++;
      end
      if (b_de) begin
        if ({b_r, b_g, b_b} !== 12'(e_pix)) bad_pix++;
        e_pix = (e_pix == 47) ? 0 : e_pix + 1;
      end else if ({b_r, b_g, b_b} !== 12'h000) begin
        bad_pix++;
      end
      if (!b_vs) begin
        if (vs_start < 0) vs_start = k;
        n_vs_low++;
      end
      if (!b_hs) n_hs_b++;
      if (b_rd) begin
        if (int'(b_addr) > max_addr) max_addr = int'(b_addr);
        if (prev_valid && prev_addr == 47 && wrap_k < 0) begin
          wrap_k = k;
          wrap_addr = int'(b_addr);
        end
        prev_addr = int'(b_addr);
        prev_valid = 1'b1;
      end
    end
    chk("b first frame_start",   fs1,       3);
    chk("b frame period",        fs2 - fs1, 150);
    chk("b vsync start",         vs_start,  108);
    chk("b vsync low clocks",    n_vs_low,  60);
    chk("b hsync low clocks",    n_hs_b,    63);
    chk("b max read addr",       max_addr,  47);
    chk("b addr after last",     wrap_addr, 0);
    chk("b wrap to frame_start", fs2,       wrap_k + 2);
    chk("b frame_start pixel",   bad_fs,    0);
    chk("b pixel stream errors", bad_pix,   0);

    // ---------------- reset pulse mid-frame at h=3, v=2
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    repeat (33) tick();
    chk("b pre-reset rd",   b_rd,            1'b1);
    chk("b pre-reset addr", b_addr,          6'd18);
    chk("b pre-reset rgb",  {b_r, b_g, b_b}, 12'h010);
    #2 b_rst = 1'b1;
    #1;
    chk("b async reset", {b_rd, b_addr, b_de, b_hs, b_vs, b_fs, b_r, b_g, b_b},
        {1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000});
    tick();
    b_rst = 1'b0;
    tick();
    chk("b post-reset rd",   b_rd,   1'b1);
    chk("b post-reset addr", b_addr, 6'd0);
    tick();
    chk("b post-reset fs early", b_fs, 1'b0);
    tick();
    chk("b post-reset fs", {b_fs, b_de, b_r, b_g, b_b}, {1'b1, 1'b1, 12'h000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
